// File: rtl/dnn_accel_word_copy_master.sv
// dnn_accel_word_copy_master
// Avalon-MM master that copies `len` 32-bit words from src_addr to dst_addr,
// one read followed by one write per word, lowest address first.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start                 command strobe, only looked at while idle
//   src_addr, dst_addr    word-aligned byte addresses (low 2 bits dropped)
//   len                   word count, 0 allowed
//   busy                  high whenever not idle
//   done                  single-cycle completion pulse
//   master_*              Avalon-MM master port (one transaction in flight)
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start, command inputs sampled here only
// RD_REQ   | read request on rd_ptr, held while waitrequest
// RD_WAIT  | read accepted, waiting for readdatavalid
// WR_REQ   | write request of captured word on wr_ptr
// DONE     | one-cycle done pulse, then back to IDLE
module dnn_accel_word_copy_master #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  output logic [3:0]        master_byteenable,
  input  logic [31:0]       master_readdata,
  input  logic              master_waitrequest,
  input  logic              master_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [LEN_W-1:0]   remaining;
  logic [31:0]        data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      remaining <= '0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_ptr    <= src_addr & ALIGN_MASK;
            wr_ptr    <= dst_addr & ALIGN_MASK;
            remaining <= len;
          end
        end
        S_RD_REQ: begin
          if (!master_waitrequest) begin
            rd_ptr <= rd_ptr + WORD_STEP;
          end
        end
        S_RD_WAIT: begin
          if (master_readdatavalid) begin
            data_q <= master_readdata;
          end
        end
        S_WR_REQ: begin
          if (!master_waitrequest) begin
            wr_ptr    <= wr_ptr + WORD_STEP;
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!master_waitrequest) begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (master_readdatavalid) begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (!master_waitrequest) begin
          state_d = (remaining == LEN_W'(1)) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state, so no master_* input reaches a
  // master_* output within the same cycle.
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign master_read       = (state_q == S_RD_REQ);
  assign master_write      = (state_q == S_WR_REQ);
  assign master_address    = (state_q == S_RD_REQ) ? rd_ptr :
                             (state_q == S_WR_REQ) ? wr_ptr : '0;
  assign master_writedata  = data_q;
  assign master_byteenable = 4'hF;

endmodule

// File: doc/dnn_accel_word_copy_master.md
# dnn_accel_word_copy_master

Avalon-MM master that copies a block of 32-bit words from a source byte address to a destination byte address, one word at a time. It is the initiator counterpart to the system's on-chip memory and other Avalon-MM slaves: it drives address/read/write/byteenable and honours waitrequest and readdatavalid. It sits beside the DNN accelerator core and moves weights and activations between on-chip buffers under control of a simple start/done command port.

## Interface
Parameters:
- ADDR_W, 32, master byte-address width.
- LEN_W, 16, word-count width.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; word-aligned; low 2 bits ignored and treated as 0.
- dst_addr  in  ADDR_W  destination byte address; word-aligned; low 2 bits ignored and treated as 0.
- len  in  LEN_W  number of 32-bit words to copy; 0 is legal.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- master_address  out  ADDR_W  byte address; low 2 bits always 0.
- master_read  out  1  read request.
- master_write  out  1  write request.
- master_writedata  out  32  write data.
- master_byteenable  out  4  constant 4'hF.
- master_readdata  in  32  read data.
- master_waitrequest  in  1  slave stall.
- master_readdatavalid  in  1  read data valid.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE, start=1:
  - Latch src_addr, dst_addr and len into internal registers (rd_ptr, wr_ptr, remaining).
  - Next state is DONE if len==0, else RD_REQ.
  - Later changes on command inputs have no effect on the transfer.
- RD_REQ:
  - master_read=1, master_address=rd_ptr.
  - Address and read are held stable while master_waitrequest=1.
  - When read=1 and waitrequest=0, the read is accepted: go to RD_WAIT and advance rd_ptr by 4.
- RD_WAIT:
  - No request asserted.
  - On master_readdatavalid=1, capture master_readdata into the data register and go to WR_REQ.
  - readdatavalid outside RD_WAIT is ignored. The interconnect guarantees read latency ≥1.
- WR_REQ:
  - master_write=1, master_address=wr_ptr, master_writedata=data register.
  - Held stable while waitrequest=1.
  - On acceptance: advance wr_ptr by 4 and decrement remaining. Go to DONE if remaining was 1, else RD_REQ.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Only one transaction is outstanding at any time. master_read and master_write are never asserted together.
- Address arithmetic is modulo 2^ADDR_W. An increment from the last word wraps to 0 with no error.
- start while busy (including in DONE) is ignored and not queued.
- Overlapping source and destination ranges are copied strictly in ascending word order, with no hazard protection.

## Timing
- Reset values: busy=0, done=0, master_read=0, master_write=0, master_address=0, master_writedata=0, master_byteenable=4'hF. State is IDLE.
- Reset mid-transfer returns to IDLE the next cycle and deasserts read/write immediately. A pending Avalon transaction is abandoned; a later readdatavalid is ignored.
- All outputs are registered or decoded from state registers only. There is no combinational path from master_* inputs to master_* outputs.
- Zero wait states and read latency 1:
  - start sampled at cycle T0.
  - RD_REQ at T0+1, RD_WAIT at T0+2, WR_REQ at T0+3.
  - Each word therefore takes 3 cycles.
  - done is high at cycle T0+1+3·len; busy falls the cycle after.
- len=0: done at T0+1 with no bus activity.
- Each waitrequest cycle, and each extra read-latency cycle, adds exactly one cycle to the word.

## Test plan
- Basic copy:
  - Stimulus: src=0x000, dst=0x400, len=4. Memory model with zero waits and latency 1; src words 0x11111111..0x44444444.
  - Response: writes to 0x400, 0x404, 0x408, 0x40C with matching data, byteenable=F. done at T0+13, a single pulse.
- Zero length:
  - Stimulus: len=0.
  - Response: done at T0+1; read and write never asserted; busy high for exactly one cycle.
- Backpressure:
  - Stimulus: waitrequest held high for 3 cycles on every read and 2 on every write; len=2.
  - Response: address, writedata and request stay stable while stalled. Exactly 2 reads and 2 writes are accepted. done at T0+1+3·2+10.
- Variable latency and wrap-around:
  - Stimulus: readdatavalid delayed 1–5 cycles at random; src=0xFFFFFFF8, len=3.
  - Response: reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; data is written in order.
- Command hygiene:
  - Stimulus: start pulsed in mid-transfer and again in the DONE cycle; src/dst/len changed during the transfer.
  - Response: the original transfer completes unchanged; there is no second transfer.
- Reset mid-transfer:
  - Stimulus: assert reset during WR_REQ of word 2 of 4, then issue a new start with len=1.
  - Response: read/write are low the cycle after reset, and all outputs hold their reset values. The new transfer completes normally with no done pulse from the aborted one.
